// File: rtl/rl_decoder.sv
// Run-length decoder: FIFO-buffered parser of literal bytes and ESC/N/D tokens into a byte stream.
// Optional macro RLD_LITERAL_ESC_EN: token count N=0 emits one literal ESC instead of a 256-byte run.
module rl_decoder #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  ESC   = 8'h1B
) (
  input  logic                    data_clk,
  input  logic                    reset_n,
  input  logic [7:0]              data_in,
  input  logic                    data_in_valid,
  output logic [7:0]              data_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow,
  output logic                    busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] ST_LIT      = 2'd0;
  localparam logic [1:0] ST_ESC_SEEN = 2'd1;
  localparam logic [1:0] ST_CNT_SEEN = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [8:0]    run_len;
  logic [8:0]    run_len_nxt;
  logic [8:0]    run_cnt;
  logic [8:0]    run_cnt_nxt;
  logic [7:0]    run_byte;
  logic [7:0]    run_byte_nxt;
  logic [7:0]    out_nxt;
  logic          out_valid_nxt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          slot_free;
  logic          push;
  logic          pop;
  logic [7:0]    pop_byte;

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign slot_free  = !data_out_valid || data_out_ready;
  // A full FIFO drops the incoming byte even if a pop frees a slot on the same edge.
  assign push       = data_in_valid && !fifo_full;
  assign pop        = !fifo_empty && (state != ST_RUN) && slot_free;
  assign pop_byte   = mem[rd_ptr];

  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CW'(1);
      2'b01:   count_nxt = fifo_count - CW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Token parser and output-slot loading.
  always_comb begin
    state_nxt     = state;
    run_len_nxt   = run_len;
    run_cnt_nxt   = run_cnt;
    run_byte_nxt  = run_byte;
    out_nxt       = data_out;
    out_valid_nxt = data_out_valid && !data_out_ready;
    case (state)
      ST_LIT: begin
        if (pop) begin
          if (pop_byte == ESC) begin
            state_nxt = ST_ESC_SEEN;
          end else begin
            out_nxt       = pop_byte;
            out_valid_nxt = 1'b1;
          end
        end
      end
      ST_ESC_SEEN: begin
        if (pop) begin
`ifdef RLD_LITERAL_ESC_EN
          if (pop_byte == 8'h00) begin
            out_nxt       = ESC;
            out_valid_nxt = 1'b1;
            state_nxt     = ST_LIT;
          end else begin
            run_len_nxt = {1'b0, pop_byte};
            state_nxt   = ST_CNT_SEEN;
          end
`else
          run_len_nxt = (pop_byte == 8'h00) ? 9'd256 : {1'b0, pop_byte};
          state_nxt   = ST_CNT_SEEN;
`endif
        end
      end
      ST_CNT_SEEN: begin
        if (pop) begin
          out_nxt       = pop_byte;
          out_valid_nxt = 1'b1;
          run_byte_nxt  = pop_byte;
          run_cnt_nxt   = run_len - 9'd1;
          state_nxt     = (run_len == 9'd1) ? ST_LIT : ST_RUN;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          out_nxt       = run_byte;
          out_valid_nxt = 1'b1;
          run_cnt_nxt   = run_cnt - 9'd1;
          if (run_cnt == 9'd1) begin
            state_nxt = ST_LIT;
          end
        end
      end
      default: state_nxt = ST_LIT;
    endcase
  end

  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_LIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge data_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      run_len        <= '0;
      run_cnt        <= '0;
      run_byte       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      overflow       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (data_in_valid && fifo_full) begin
        overflow <= 1'b1;
      end
      fifo_count     <= count_nxt;
      run_len        <= run_len_nxt;
      run_cnt        <= run_cnt_nxt;
      run_byte       <= run_byte_nxt;
      data_out       <= out_nxt;
      data_out_valid <= out_valid_nxt;
      busy           <= (state_nxt != ST_LIT) || (count_nxt != '0);
    end
  end

  // Storage array carries no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge data_clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_rl_decoder.sv
// Directed testbench for rl_decoder: literals, runs, backpressure, overflow, escape zero, async reset.
module tb_rl_decoder;

  logic       data_clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic [4:0] fifo_count;
  logic       overflow;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fifo_max = 0;
  logic [7:0] q[$];

  rl_decoder #(.DEPTH(16), .ESC(8'h1B)) dut (
    .data_clk       (data_clk),
    .reset_n        (reset_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .busy           (busy)
  );

  initial data_clk = 1'b0;
  always #5 data_clk = ~data_clk;

  // Record every accepted byte; sampled mid-cycle, ahead of the handshake edge.
  always @(negedge data_clk) begin
    if (reset_n && data_out_valid && data_out_ready) q.push_back(data_out);
  end

  task automatic step();
    @(posedge data_clk);
    #1;
    if (int'(fifo_count) > fifo_max) fifo_max = int'(fifo_count);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n = 0;
    while ((busy || data_out_valid) && n < max_cycles) begin
      step();
      n++;
    end
    chk(tag, 32'(busy || data_out_valid), 32'd0);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    data_in = a; data_in_valid = 1'b1; step();
    data_in = b; step();
    data_in = c; step();
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;
    data_in = 8'h00;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    step();
    step();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_out_valid), 32'h0);
    chk("rst_fifo_count", 32'(fifo_count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    step();

    // Literal stream
    data_in = 8'h41; data_in_valid = 1'b1; step();
    chk("lit_no_early_valid", 32'(data_out_valid), 32'h0);
    chk("lit_count_after_push", 32'(fifo_count), 32'd1);
    data_in = 8'h42; step();
    chk("lit_0x41_valid", 32'(data_out_valid), 32'h1);
    chk("lit_0x41", 32'(data_out), 32'h41);
    data_in = 8'h43; step();
    chk("lit_0x42", 32'(data_out), 32'h42);
    data_in_valid = 1'b0; step();
    chk("lit_0x43", 32'(data_out), 32'h43);
    chk("lit_0x43_valid", 32'(data_out_valid), 32'h1);
    step();
    chk("lit_valid_drop", 32'(data_out_valid), 32'h0);
    chk("lit_overflow", 32'(overflow), 32'h0);
    chk("lit_busy", 32'(busy), 32'h0);

    // Run token 1B 05 7E
    q.delete();
    push3(8'h1B, 8'h05, 8'h7E);
    chk("run_no_early_valid", 32'(data_out_valid), 32'h0);
    data_in_valid = 1'b0; step();
    chk("run_first_valid", 32'(data_out_valid), 32'h1);
    chk("run_first_byte", 32'(data_out), 32'h7E);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_copy_valid", 32'(data_out_valid), 32'h1);
      chk("run_copy_byte", 32'(data_out), 32'h7E);
    end
    step();
    chk("run_end_valid", 32'(data_out_valid), 32'h0);
    chk("run_end_busy", 32'(busy), 32'h0);
    chk("run_count", 32'(q.size()), 32'd5);

    // Backpressure mid-run
    q.delete();
    push3(8'h1B, 8'h03, 8'h55);
    data_in_valid = 1'b0; step();
    chk("bp_first", 32'(data_out), 32'h55);
    step();
    data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_valid", 32'(data_out_valid), 32'h1);
      chk("bp_hold_byte", 32'(data_out), 32'h55);
    end
    data_out_ready = 1'b1;
    wait_idle(20, "bp_timeout");
    chk("bp_handshakes", 32'(q.size()), 32'd3);
    bad = 0;
    foreach (q[i]) if (q[i] !== 8'h55) bad++;
    chk("bp_bytes", 32'(bad), 32'd0);

    // Escape with count zero
    q.delete();
    push3(8'h1B, 8'h00, 8'h22);
    data_in_valid = 1'b0;
    wait_idle(400, "esc0_timeout");
`ifdef RLD_LITERAL_ESC_EN
    chk("esc0_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("esc0_literal", 32'(q[0]), 32'h1B);
      chk("esc0_data", 32'(q[1]), 32'h22);
    end
`else
    chk("esc0_count", 32'(q.size()), 32'd256);
    bad = 0;
    foreach (q[i]) if (q[i] !== 8'h22) bad++;
    chk("esc0_bytes", 32'(bad), 32'd0);
`endif

    // Overflow: long run while 40 literals stream in
    q.delete();
    fifo_max = 0;
    push3(8'h1B, 8'hFF, 8'h11);
    for (int i = 0; i < 40; i++) begin
      data_in = 8'h80 + 8'(i);
      step();
      if (i == 15) begin
        chk("ovf_full_count", 32'(fifo_count), 32'd16);
        chk("ovf_not_yet", 32'(overflow), 32'h0);
      end
      if (i == 16) chk("ovf_set", 32'(overflow), 32'h1);
    end
    data_in_valid = 1'b0;
    wait_idle(600, "ovf_timeout");
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_max_count", 32'(fifo_max), 32'd16);
    chk("ovf_total", 32'(q.size()), 32'd271);
    bad = 0;
    foreach (q[i]) begin
      if (i < 255) begin
        if (q[i] !== 8'h11) bad++;
      end else begin
        if (q[i] !== 8'h80 + 8'(i - 255)) bad++;
      end
    end
    chk("ovf_order", 32'(bad), 32'd0);

    // Asynchronous reset during the third output of a run
    push3(8'h1B, 8'h0A, 8'h33);
    data_in_valid = 1'b0;
    step();
    step();
    step();
    chk("rr_third_valid", 32'(data_out_valid), 32'h1);
    chk("rr_third_byte", 32'(data_out), 32'h33);
    #2 reset_n = 1'b0;
    #1;
    chk("rr_data_out", 32'(data_out), 32'h0);
    chk("rr_valid", 32'(data_out_valid), 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_overflow", 32'(overflow), 32'h0);
    chk("rr_fifo_count", 32'(fifo_count), 32'h0);
    step();
    reset_n = 1'b1;
    data_in = 8'h44; data_in_valid = 1'b1; step();
    data_in_valid = 1'b0; step();
    chk("rr_lit_valid", 32'(data_out_valid), 32'h1);
    chk("rr_lit_byte", 32'(data_out), 32'h44);
    step();
    chk("rr_idle", 32'(busy || data_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
